// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-rate default, framing constants, FSM states.
// Optional parity support is compiled in when UART_RX_PARITY_EN is defined.
package uart_pkg;

  // 50 MHz / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } uart_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals asynchronous to the local clock.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops to let metastability resolve before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), optional even parity, 1 stop.
// Define UART_RX_PARITY_EN to add the parity bit between data and stop.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle; waits for rx_s high (armed) then a falling edge
// ST_START  | counts half a bit, confirms start bit is still low
// ST_DATA   | samples 8 data bits at mid-bit, LSB first
// ST_PARITY | samples the even-parity bit (parity build only)
// ST_STOP   | samples the stop bit, emits rx_complete or frame_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_msg,
  output logic       rx_complete,
  output logic       frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  uart_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  // armed: line has been seen high since reset or the last break, so a low
  // level now really is a start edge.
  logic             armed;
  // settle: ignore the synchronizer's reset value until real samples arrive.
  logic [1:0]       settle;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad;
`endif

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk_50M),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Receive FSM with bit-period counter and registered output pulses.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      data_q      <= '0;
      armed       <= 1'b0;
      settle      <= '0;
      rx_msg      <= 8'h00;
      rx_complete <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad  <= 1'b0;
`endif
    end else begin
      rx_complete <= 1'b0;
      frame_err   <= 1'b0;
      settle      <= {settle[0], 1'b1};

      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          parity_bad <= 1'b0;
`endif
          if (!armed) begin
            if (settle[1] && rx_s == STOP_BIT) armed <= 1'b1;
          end else if (rx_s == START_BIT) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (cnt == HALF_TC) begin
            cnt   <= '0;
            // A start bit that has gone high by mid-bit is a glitch.
            state <= (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt == BIT_TC) begin
            cnt             <= '0;
            data_q[bit_idx] <= rx_s;
            bit_idx         <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == BIT_TC) begin
            cnt        <= '0;
            parity_bad <= (rx_s != even_parity(data_q));
            state      <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (cnt == BIT_TC) begin
            cnt   <= '0;
            // Leave mid stop bit so a start edge at its nominal end is caught.
            state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (rx_s == STOP_BIT && !parity_bad) begin
`else
            if (rx_s == STOP_BIT) begin
`endif
              rx_msg      <= data_q;
              rx_complete <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              // A low stop bit may be a break; wait for the line to go high.
              if (rx_s != STOP_BIT) armed <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (honours UART_RX_PARITY_EN).
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 434;

  logic       clk_50M = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       frame_err;

  int vectors    = 0;
  int miscompares = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;
  logic [7:0] msg_log[$];
  int base_done, base_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .rx          (rx),
    .rx_msg      (rx_msg),
    .rx_complete (rx_complete),
    .frame_err   (frame_err)
  );

  always #10 clk_50M = ~clk_50M;

  // Pulse monitor: counts high cycles of each output, away from the edge.
  always @(negedge clk_50M) begin
    if (rx_complete) begin
      n_done++;
      msg_log.push_back(rx_msg);
    end
    if (frame_err) n_err++;
    if (rx_complete && frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_period(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk_50M);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_period(par_v);
`else
    if (par_v === 1'bx) rx = 1'b1;
`endif
    bit_period(stop_v);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_50M);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk_50M);
    check("reset_msg",      32'(rx_msg), 32'h00);
    check("reset_complete", 32'(rx_complete), 32'h0);
    check("reset_ferr",     32'(frame_err), 32'h0);
    check("reset_state",    32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    idle(20);

    // Single frame 0x63
    base_done = n_done; base_err = n_err;
    send_frame(8'h63, 1'b1, 1'b0);
    idle(20);
    check("h63_pulses", 32'(n_done - base_done), 32'd1);
    check("h63_ferr",   32'(n_err - base_err), 32'd0);
    check("h63_msg",    32'(rx_msg), 32'h63);

    // Back-to-back 0x00 then 0xFF, no idle gap
    base_done = n_done;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    check("b2b_pulses", 32'(n_done - base_done), 32'd2);
    check("b2b_first",  32'(msg_log[base_done]), 32'h00);
    check("b2b_second", 32'(msg_log[base_done + 1]), 32'hFF);
    check("b2b_ferr",   32'(n_err - base_err), 32'd0);

    // 100-clock glitch low, then a 0xA5 frame
    base_done = n_done;
    rx = 1'b0;
    repeat (100) @(negedge clk_50M);
    idle(2 * CPB);
    check("glitch_pulses", 32'(n_done - base_done + n_err - base_err), 32'd0);
    check("glitch_state",  32'(dut.state), 32'(ST_IDLE));
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("hA5_pulses", 32'(n_done - base_done), 32'd1);
    check("hA5_msg",    32'(rx_msg), 32'hA5);

    // 0x3C with stop bit 0, followed by a break
    base_done = n_done; base_err = n_err;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk_50M);
    check("ferr_state_in_break", 32'(dut.state), 32'(ST_IDLE));
    check("ferr_pulses",   32'(n_err - base_err), 32'd1);
    check("ferr_complete", 32'(n_done - base_done), 32'd0);
    check("ferr_msg_kept", 32'(rx_msg), 32'hA5);
    idle(CPB);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    check("after_break_msg",  32'(rx_msg), 32'h81);
    check("after_break_ferr", 32'(n_err - base_err), 32'd1);

    // Reset during data bit 4 of 0x5A, held until the frame has passed
    base_done = n_done; base_err = n_err;
    bit_period(1'b0);
    bit_period(1'b0); bit_period(1'b1); bit_period(1'b0); bit_period(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk_50M);
    rst = 1'b1;
    repeat (5) @(negedge clk_50M);
    check("midrst_msg",      32'(rx_msg), 32'h00);
    check("midrst_complete", 32'(rx_complete), 32'h0);
    check("midrst_ferr",     32'(frame_err), 32'h0);
    check("midrst_state",    32'(dut.state), 32'(ST_IDLE));
    repeat (CPB / 2 - 5) @(negedge clk_50M);
    bit_period(1'b0); bit_period(1'b1); bit_period(1'b0);
`ifdef UART_RX_PARITY_EN
    bit_period(1'b0);
`endif
    bit_period(1'b1);
    rst = 1'b0;
    idle(CPB);
    check("midrst_no_pulse", 32'(n_done - base_done + n_err - base_err), 32'd0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(20);
    check("hC3_pulses", 32'(n_done - base_done), 32'd1);
    check("hC3_msg",    32'(rx_msg), 32'hC3);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    base_done = n_done; base_err = n_err;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("par_bad_ferr",     32'(n_err - base_err), 32'd1);
    check("par_bad_complete", 32'(n_done - base_done), 32'd0);
    check("par_bad_msg",      32'(rx_msg), 32'hC3);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_ok_complete", 32'(n_done - base_done), 32'd1);
    check("par_ok_msg",      32'(rx_msg), 32'h07);
    check("par_ok_ferr",     32'(n_err - base_err), 32'd1);
`endif

    check("no_overlap", 32'(n_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
